zoom_engine: RTL and testbench

ZOOM_ENGINE -- requirements
Module: zoom_engine

---
 rtl/zoom_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_zoom_engine.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_engine.sv
// zoom_engine: fixed-ratio image zoom between a source and a destination frame
// buffer. One output pixel is produced per RD -> WT -> WR sequence (3 cycles);
// the box-average mode (ALGORITHM 2'b11) reads a 2x2 block with four RD/WT
// pairs before its single WR (9 cycles).
//
//   ALGORITHM 2'b00 NN : 2x nearest neighbour, region 2*SRC_W x 2*SRC_H
//   ALGORITHM 2'b01 PR : 4x pixel replication, region 4*SRC_W x 4*SRC_H
//   ALGORITHM 2'b10 DC : 2:1 decimation,       region SRC_W/2 x SRC_H/2
//   ALGORITHM 2'b11 BA : 2x2 box average,      region SRC_W/2 x SRC_H/2
//
// Optional feature: define ZOOM_ENGINE_CLEAR_EN to zero the whole destination
// (DST_W*DST_H words, one per cycle) before the zoom pass starts.
//
// Ports:
//   CLK        in   rising-edge clock
//   RESET      in   asynchronous active-high reset
//   START      in   request, sampled only while idle
//   ALGORITHM  in   zoom mode, latched with START
//   RD_EN      out  source read strobe
//   RD_ADDR    out  source address (sy*SRC_W + sx)
//   RD_DATA    in   source pixel, valid the cycle after RD_EN
//   WR_EN      out  destination write strobe
//   WR_ADDR    out  destination address (dy*DST_W + dx)
//   WR_DATA    out  destination pixel
//   BUSY       out  operation in progress
//   DONE       out  one-cycle completion pulse
module zoom_engine #(
    parameter int unsigned SRC_W  = 160,
    parameter int unsigned SRC_H  = 120,
    parameter int unsigned DST_W  = 640,
    parameter int unsigned DST_H  = 480,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned SRC_AW = 15,
    parameter int unsigned DST_AW = 19
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [1:0]        ALGORITHM,
    output logic              RD_EN,
    output logic [SRC_AW-1:0] RD_ADDR,
    input  logic [PIX_W-1:0]  RD_DATA,
    output logic              WR_EN,
    output logic [DST_AW-1:0] WR_ADDR,
    output logic [PIX_W-1:0]  WR_DATA,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [1:0] ALG_NN = 2'b00;
    localparam logic [1:0] ALG_PR = 2'b01;
    localparam logic [1:0] ALG_BA = 2'b11;

    localparam logic [DST_AW-1:0] CLR_LAST = DST_AW'(DST_W * DST_H - 1);

    typedef enum logic [2:0] {StIdle, StClr, StRd, StWt, StWr, StDone} state_e;

    state_e            state;
    logic [1:0]        alg;
    logic [1:0]        phase;     // BA block position: bit0 = +x, bit1 = +y
    logic [DST_AW-1:0] dx;
    logic [DST_AW-1:0] dy;
    logic [DST_AW-1:0] dst_row;   // dy * DST_W
    logic [SRC_AW-1:0] src_row;   // sy * SRC_W of the current output row
    logic [PIX_W+1:0]  acc;
    logic              last;

    logic [DST_AW-1:0] out_w;
    logic [DST_AW-1:0] out_h;
    logic [1:0]        ph_nxt;
    logic [SRC_AW-1:0] sx;
    logic [SRC_AW-1:0] rd_addr_nxt;
    logic [PIX_W+1:0]  sum;

    // Output region size for the latched mode.
    always_comb begin
        out_w = '0;
        out_h = '0;
        unique case (alg)
            2'b00: begin
                out_w = DST_AW'(2 * SRC_W);
                out_h = DST_AW'(2 * SRC_H);
            end
            2'b01: begin
                out_w = DST_AW'(4 * SRC_W);
                out_h = DST_AW'(4 * SRC_H);
            end
            default: begin
                out_w = DST_AW'(SRC_W / 2);
                out_h = DST_AW'(SRC_H / 2);
            end
        endcase
    end

    // Address of the next source read. Leaving WT it is the next block
    // position of the same pixel; leaving WR the counters have already
    // advanced to the next pixel, so phase restarts at 0.
    always_comb begin
        ph_nxt = (state == StWt) ? phase + 2'd1 : 2'd0;
        sx     = '0;
        unique case (alg)
            2'b00:   sx = SRC_AW'(dx >> 1);
            2'b01:   sx = SRC_AW'(dx >> 2);
            default: sx = SRC_AW'(dx << 1);
        endcase
        rd_addr_nxt = src_row + sx
                    + (ph_nxt[1] ? SRC_AW'(SRC_W) : '0)
                    + SRC_AW'(ph_nxt[0]);
    end

    // BA running sum; the first sample of a block restarts it.
    always_comb begin
        sum = ((phase == 2'd0) ? '0 : acc) + {2'b00, RD_DATA};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= StIdle;
            alg     <= '0;
            phase   <= '0;
            dx      <= '0;
            dy      <= '0;
            dst_row <= '0;
            src_row <= '0;
            acc     <= '0;
            last    <= 1'b0;
            RD_EN   <= 1'b0;
            RD_ADDR <= '0;
            WR_EN   <= 1'b0;
            WR_ADDR <= '0;
            WR_DATA <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    DONE <= 1'b0;
                    if (START) begin
                        alg     <= ALGORITHM;
                        phase   <= '0;
                        dx      <= '0;
                        dy      <= '0;
                        dst_row <= '0;
                        src_row <= '0;
                        last    <= 1'b0;
                        BUSY    <= 1'b1;
`ifdef ZOOM_ENGINE_CLEAR_EN
                        state   <= StClr;
                        WR_EN   <= 1'b1;
                        WR_ADDR <= '0;
                        WR_DATA <= '0;
`else
                        state   <= StRd;
                        RD_EN   <= 1'b1;
                        RD_ADDR <= '0;
`endif
                    end
                end

                // WR_ADDR doubles as the clear counter.
                StClr: begin
                    if (WR_ADDR == CLR_LAST) begin
                        state   <= StRd;
                        WR_EN   <= 1'b0;
                        RD_EN   <= 1'b1;
                        RD_ADDR <= '0;
                    end else begin
                        WR_ADDR <= WR_ADDR + 1'b1;
                    end
                end

                StRd: begin
                    RD_EN <= 1'b0;
                    state <= StWt;
                end

                StWt: begin
                    acc <= sum;
                    if (alg == ALG_BA && phase != 2'd3) begin
                        phase   <= phase + 2'd1;
                        RD_EN   <= 1'b1;
                        RD_ADDR <= rd_addr_nxt;
                        state   <= StRd;
                    end else begin
                        phase   <= '0;
                        WR_EN   <= 1'b1;
                        WR_ADDR <= dst_row + dx;
                        WR_DATA <= (alg == ALG_BA) ? sum[PIX_W+1:2] : RD_DATA;
                        state   <= StWr;
                        last    <= (dx == out_w - 1'b1) && (dy == out_h - 1'b1);
                        // Advance to the next output pixel in raster order.
                        if (dx == out_w - 1'b1) begin
                            dx      <= '0;
                            dy      <= dy + 1'b1;
                            dst_row <= dst_row + DST_AW'(DST_W);
                            unique case (alg)
                                ALG_NN: begin
                                    if (dy[0]) src_row <= src_row + SRC_AW'(SRC_W);
                                end
                                ALG_PR: begin
                                    if (dy[1:0] == 2'b11) src_row <= src_row + SRC_AW'(SRC_W);
                                end
                                default: src_row <= src_row + SRC_AW'(2 * SRC_W);
                            endcase
                        end else begin
                            dx <= dx + 1'b1;
                        end
                    end
                end

                StWr: begin
                    WR_EN <= 1'b0;
                    if (last) begin
                        state <= StDone;
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                    end else begin
                        state   <= StRd;
                        RD_EN   <= 1'b1;
                        RD_ADDR <= rd_addr_nxt;
                    end
                end

                StDone: begin
                    DONE  <= 1'b0;
                    state <= StIdle;
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_zoom_engine.sv
// tb_zoom_engine: directed bench for zoom_engine on a reduced 11x7 source and
// 48x30 destination (odd source sizes exercise the dropped trailing column/row
// in DC/BA; the stride exceeds every region width). A source memory answers
// reads one cycle late; a negedge monitor records every write and checks it
// against an independent div/mod model of address and pixel value.
module tb_zoom_engine;

    localparam int SW  = 11;
    localparam int SH  = 7;
    localparam int DW  = 48;
    localparam int DH  = 30;
    localparam int SAW = 7;
    localparam int DAW = 11;
`ifdef ZOOM_ENGINE_CLEAR_EN
    localparam int CLR_N = DW * DH;
`else
    localparam int CLR_N = 0;
`endif

    logic           clk;
    logic           rst;
    logic           start;
    logic [1:0]     alg;
    logic           rd_en;
    logic [SAW-1:0] rd_addr;
    logic [7:0]     rd_data;
    logic           wr_en;
    logic [DAW-1:0] wr_addr;
    logic [7:0]     wr_data;
    logic           busy;
    logic           done;

    zoom_engine #(
        .SRC_W (SW),
        .SRC_H (SH),
        .DST_W (DW),
        .DST_H (DH),
        .PIX_W (8),
        .SRC_AW(SAW),
        .DST_AW(DAW)
    ) dut (
        .CLK      (clk),
        .RESET    (rst),
        .START    (start),
        .ALGORITHM(alg),
        .RD_EN    (rd_en),
        .RD_ADDR  (rd_addr),
        .RD_DATA  (rd_data),
        .WR_EN    (wr_en),
        .WR_ADDR  (wr_addr),
        .WR_DATA  (wr_data),
        .BUSY     (busy),
        .DONE     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] src_mem [SW*SH];
    logic [7:0] dst_mem [DW*DH];

    // Source memory: data valid exactly one cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < SW * SH) rd_data <= src_mem[int'(rd_addr)];
        else                                  rd_data <= 8'hA5;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Operation context, written by the stimulus, read by the monitor.
    int chk_alg   = 0;
    int wr_base   = 0;
    int rd_base   = 0;
    int done_base = 0;
    int start_cyc = 0;

    // Monitor state.
    int ncyc         = 0;
    int wr_count     = 0;
    int rd_count     = 0;
    int done_count   = 0;
    int done_cyc     = 0;
    int first_wr_cyc = 0;
    int first_rd_cyc = 0;
    int last_wr_addr = 0;
    int model_err    = 0;
    int overlap_err  = 0;
    int pulse_err    = 0;
    int hold_err     = 0;
    int busy_err     = 0;
    int bound_err    = 0;
    logic           rst_prev  = 1'b1;
    logic           p_rd_en   = 1'b0;
    logic [SAW-1:0] p_rd_addr = '0;
    logic [DAW-1:0] p_wr_addr = '0;
    logic [7:0]     p_wr_data = '0;

    function automatic int src_px(input int x, input int y);
        return int'(src_mem[y * SW + x]);
    endfunction

    function automatic int reg_w(input int a);
        case (a)
            0:       return 2 * SW;
            1:       return 4 * SW;
            default: return SW / 2;
        endcase
    endfunction

    function automatic int exp_pix(input int a, input int x, input int y);
        case (a)
            0:       return src_px(x / 2, y / 2);
            1:       return src_px(x / 4, y / 4);
            2:       return src_px(2 * x, 2 * y);
            default: return (src_px(2 * x, 2 * y) + src_px(2 * x + 1, 2 * y) +
                             src_px(2 * x, 2 * y + 1) + src_px(2 * x + 1, 2 * y + 1)) >> 2;
        endcase
    endfunction

    function automatic int exp_addr(input int idx);
        if (idx < CLR_N) return idx;
        return ((idx - CLR_N) / reg_w(chk_alg)) * DW + (idx - CLR_N) % reg_w(chk_alg);
    endfunction

    function automatic int exp_data(input int idx);
        if (idx < CLR_N) return 0;
        return exp_pix(chk_alg, (idx - CLR_N) % reg_w(chk_alg), (idx - CLR_N) / reg_w(chk_alg));
    endfunction

    // The cycle being sampled is ncyc + 1.
    always @(negedge clk) begin
        ncyc      <= ncyc + 1;
        rst_prev  <= rst;
        p_rd_en   <= rd_en;
        p_rd_addr <= rd_addr;
        p_wr_addr <= wr_addr;
        p_wr_data <= wr_data;
        if (rd_en && wr_en) overlap_err <= overlap_err + 1;
        if (rd_en && p_rd_en) pulse_err <= pulse_err + 1;
        if (!rst && !rst_prev &&
            ((!wr_en && (wr_addr != p_wr_addr || wr_data != p_wr_data)) ||
             (!rd_en && rd_addr != p_rd_addr)))
            hold_err <= hold_err + 1;
        if (wr_en) begin
            wr_count     <= wr_count + 1;
            last_wr_addr <= int'(wr_addr);
            if (int'(wr_addr) < DW * DH) dst_mem[int'(wr_addr)] <= wr_data;
            if (wr_count == wr_base) first_wr_cyc <= ncyc + 1;
            if (int'(wr_addr) != exp_addr(wr_count - wr_base) ||
                int'(wr_data) != exp_data(wr_count - wr_base))
                model_err <= model_err + 1;
        end
        if (rd_en) begin
            rd_count <= rd_count + 1;
            if (rd_count == rd_base) first_rd_cyc <= ncyc + 1;
            if (chk_alg >= 2 && (int'(rd_addr) % SW >= 2 * (SW / 2) ||
                                 int'(rd_addr) / SW >= 2 * (SH / 2)))
                bound_err <= bound_err + 1;
        end
        if (done) begin
            done_count <= done_count + 1;
            done_cyc   <= ncyc + 1;
            if (busy) busy_err <= busy_err + 1;
        end
    end

    task automatic kick(input logic [1:0] a);
        @(negedge clk);
        #1;
        alg       = a;
        start     = 1'b1;
        chk_alg   = int'(a);
        wr_base   = wr_count;
        rd_base   = rd_count;
        done_base = done_count;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = ncyc;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) break;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        alg   = 2'b00;
        for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++)
                src_mem[y * SW + x] = 8'((x + y) & 8'hFF);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {rd_en, wr_en, busy, done}, 4'b0000);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        #1 rst = 1'b0;

        // NN 2x: 22x14 region, 3 cycles/pixel.
        kick(2'b00);
        @(negedge clk);
        check("nn_busy", busy, 1);
        wait_done(CLR_N + 1000);
        check("nn_done_cyc", done_cyc - start_cyc, CLR_N + 3 * 308 + 1);
        check("nn_first_rd", first_rd_cyc - start_cyc, CLR_N + 1);
        check("nn_writes", wr_count - wr_base, CLR_N + 308);
        check("nn_dones", done_count - done_base, 1);
        check("nn_px_5_3", dst_mem[5 * DW + 3], 3);
        check("nn_last_addr", last_wr_addr, 13 * DW + 21);
        check("nn_last_px", dst_mem[13 * DW + 21], 16);
        check("nn_idle", {busy, done, rd_en, wr_en}, 4'b0000);
        check("nn_model", model_err, 0);

        // BA: 5x3 region, 9 cycles/pixel, 10-bit sum.
        src_mem[0]  = 8'd10;
        src_mem[1]  = 8'd11;
        src_mem[11] = 8'd12;
        src_mem[12] = 8'd14;
        src_mem[2]  = 8'd255;
        src_mem[3]  = 8'd255;
        src_mem[13] = 8'd255;
        src_mem[14] = 8'd254;
        kick(2'b11);
        wait_done(CLR_N + 300);
        check("ba_px0", dst_mem[0], 11);
        check("ba_px1_wide", dst_mem[1], 254);
        check("ba_px_2_4", dst_mem[2 * DW + 4], 13);
        check("ba_first_wr", first_wr_cyc - start_cyc, (CLR_N > 0) ? 1 : 9);
        check("ba_done_cyc", done_cyc - start_cyc, CLR_N + 9 * 15 + 1);
        check("ba_writes", wr_count - wr_base, CLR_N + 15);
        check("ba_last_addr", last_wr_addr, 2 * DW + 4);
        check("ba_model", model_err, 0);

        // PR 4x: 44x28 region.
        kick(2'b01);
        wait_done(CLR_N + 5000);
        for (int i = 0; i < 4; i++) check($sformatf("pr_px%0d", i), dst_mem[i], 10);
        check("pr_px4", dst_mem[4], 11);
        check("pr_row4", dst_mem[4 * DW], 12);
        check("pr_writes", wr_count - wr_base, CLR_N + 1232);
        check("pr_last_addr", last_wr_addr, 27 * DW + 43);
        check("pr_last_px", dst_mem[27 * DW + 43], 16);
        check("pr_done_cyc", done_cyc - start_cyc, CLR_N + 3 * 1232 + 1);
        check("pr_model", model_err, 0);

        // DC with START and ALGORITHM disturbed mid-run.
        kick(2'b10);
        repeat (19) @(negedge clk);
        #1;
        start = 1'b1;
        alg   = 2'b00;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(CLR_N + 200);
        repeat (10) @(negedge clk);
        check("dc_dones", done_count - done_base, 1);
        check("dc_writes", wr_count - wr_base, CLR_N + 15);
        check("dc_done_cyc", done_cyc - start_cyc, CLR_N + 3 * 15 + 1);
        check("dc_px_0_1", dst_mem[1], 255);
        check("dc_px_1_1", dst_mem[DW + 1], 4);
        check("dc_px_2_4", dst_mem[2 * DW + 4], 12);
        check("dc_model", model_err, 0);

        // Reset mid NN run, then DC started on the first edge after release.
        kick(2'b00);
        repeat (299) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_rst_strobes", {rd_en, wr_en, busy, done}, 4'b0000);
        check("mid_rst_rd_addr", rd_addr, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        check("mid_rst_wr_data", wr_data, 0);
        #1;
        rst       = 1'b0;
        alg       = 2'b10;
        start     = 1'b1;
        chk_alg   = 2;
        wr_base   = wr_count;
        rd_base   = rd_count;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = ncyc;
        wait_done(CLR_N + 200);
        check("post_rst_dones", done_count - done_base, 1);
        check("post_rst_done_cyc", done_cyc - start_cyc, CLR_N + 3 * 15 + 1);
        check("post_rst_writes", wr_count - wr_base, CLR_N + 15);
        check("post_rst_px_1_1", dst_mem[DW + 1], 4);
        check("post_rst_model", model_err, 0);

        // Protocol rules over the whole run.
        check("rd_wr_overlap", overlap_err, 0);
        check("rd_pulse_width", pulse_err, 0);
        check("hold_when_idle", hold_err, 0);
        check("busy_in_done", busy_err, 0);
        check("odd_edge_reads", bound_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
